encoder83_queue: RTL and testbench

Sequential 8-to-3 encoder, the transmit-side counterpart of the 3-to-8 decoder. It captures rising edges on eight request lines into a pending register and serves them one at a time by priority. Each served request is presented as a 3-bit code {A,B,C} under a valid/ready handshake, so the code can drive a decoder directly or cross to a slower consumer. It sits between raw event lines (buttons, interrupt sources) and any block that consumes a binary index.

---
 rtl/encoder83_pkg.sv | 18 +
 rtl/encoder83_queue_prio_enc8.sv | 27 ++
 rtl/encoder83_queue.sv | 108 ++++++++++
 tb/tb_encoder83_queue.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/encoder83_pkg.sv
// Shared constants, FSM state type and index helpers for the 8-to-3 event encoder.
package encoder83_pkg;

   localparam int CODE_W = 3;
   localparam int N_REQ  = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   function automatic logic [N_REQ-1:0] onehot8(input logic [CODE_W-1:0] idx);
      logic [N_REQ-1:0] mask;
      mask = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
      return mask;
   endfunction

endpackage

// File: rtl/encoder83_queue_prio_enc8.sv
// Combinational 8-input priority encoder; PRIORITY_HIGH picks which end of the mask wins.
module prio_enc8
   import encoder83_pkg::*;
#(
   parameter bit PRIORITY_HIGH = 1'b1
) (
   input  logic [N_REQ-1:0]  mask,
   output logic [CODE_W-1:0] idx,
   output logic              any
);

   // Scan toward the priority end so the last set bit found is the winner.
   always_comb begin
      idx = {CODE_W{1'b0}};
      any = |mask;
      for (int i = 0; i < N_REQ; i++) begin
         int j;
         j = PRIORITY_HIGH ? i : (N_REQ - 1 - i);
         if (mask[j]) begin
            idx = CODE_W'(j);
         end else begin
            idx = idx;
         end
      end
   end

endmodule

// File: rtl/encoder83_queue.sv
// Captures rising edges on eight request lines and serves them one at a time
// as a 3-bit code {A,B,C} under a valid/ready handshake.
module encoder83_queue
   import encoder83_pkg::*;
#(
   parameter bit PRIORITY_HIGH = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             ready,
   output logic             A,
   output logic             B,
   output logic             C,
   output logic             valid,
   output logic [N_REQ-1:0] pending,
   output logic             lost
);

   state_t              state_r;
   logic [N_REQ-1:0]    req_q_r;
   logic [N_REQ-1:0]    pending_r;
   logic [CODE_W-1:0]   code_r;
   logic                valid_r;
   logic                lost_r;

   logic [N_REQ-1:0]    rise_s;
   logic [N_REQ-1:0]    clr_s;
   logic [CODE_W-1:0]   sel_idx_s;
   logic                sel_any_s;
   logic                load_s;

   prio_enc8 #(
      .PRIORITY_HIGH (PRIORITY_HIGH)
   ) u_prio (
      .mask (pending_r),
      .idx  (sel_idx_s),
      .any  (sel_any_s)
   );

   // Selection sees only registered pending, so same-cycle rises wait a cycle.
   always_comb begin
      rise_s = req & ~req_q_r;
      load_s = sel_any_s && ((state_r == IDLE) || ready);
      if (load_s) begin
         clr_s = onehot8(sel_idx_s);
      end else begin
         clr_s = {N_REQ{1'b0}};
      end
   end

   // Edge capture and pending set/clear; a rise on the bit being cleared is kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q_r   <= {N_REQ{1'b0}};
         pending_r <= {N_REQ{1'b0}};
         lost_r    <= 1'b0;
      end else begin
         req_q_r   <= req;
         pending_r <= (pending_r & ~clr_s) | rise_s;
         lost_r    <= |(rise_s & pending_r & ~clr_s);
      end
   end

   // Output FSM: code and valid only change when the output register is free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         valid_r <= 1'b0;
         code_r  <= {CODE_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (sel_any_s) begin
                  code_r  <= sel_idx_s;
                  valid_r <= 1'b1;
                  state_r <= SEND;
               end else begin
                  valid_r <= 1'b0;
               end
            end
            SEND: begin
               if (ready && sel_any_s) begin
                  code_r  <= sel_idx_s;
                  valid_r <= 1'b1;
               end else if (ready) begin
                  valid_r <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  valid_r <= 1'b1;
               end
            end
            default: begin
               valid_r <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign A       = code_r[2];
   assign B       = code_r[1];
   assign C       = code_r[0];
   assign valid   = valid_r;
   assign pending = pending_r;
   assign lost    = lost_r;

endmodule

// File: tb/tb_encoder83_queue.sv
// Bench for encoder83_queue: directed table, reset-in-flight sequence and a
// randomized run against an event-queue model, for both priority directions.
module tb_encoder83_queue;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       ready;

   logic       a_hi, b_hi, c_hi, valid_hi, lost_hi;
   logic [7:0] pend_hi;
   logic       a_lo, b_lo, c_lo, valid_lo, lost_lo;
   logic [7:0] pend_lo;

   int n_vec;
   int n_fail;

   encoder83_queue #(.PRIORITY_HIGH(1'b1)) dut_hi (
      .clk (clk), .rst (rst), .req (req), .ready (ready),
      .A (a_hi), .B (b_hi), .C (c_hi), .valid (valid_hi),
      .pending (pend_hi), .lost (lost_hi)
   );

   encoder83_queue #(.PRIORITY_HIGH(1'b0)) dut_lo (
      .clk (clk), .rst (rst), .req (req), .ready (ready),
      .A (a_lo), .B (b_lo), .C (c_lo), .valid (valid_lo),
      .pending (pend_lo), .lost (lost_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: index 0 tracks the high-priority instance, 1 the low one.
   logic [7:0] m_req_q;
   logic [7:0] m_pend [2];
   logic       m_valid[2];
   logic [2:0] m_code [2];
   logic       m_lost [2];

   typedef struct {
      logic [7:0] req;
      logic       ready;
      logic       valid;
      logic [2:0] code;
      logic [7:0] pend;
      logic       lost;
   } vec_t;

   vec_t tbl[30];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_req_q = 8'h00;
      for (int p = 0; p < 2; p++) begin
         m_pend[p]  = 8'h00;
         m_valid[p] = 1'b0;
         m_code[p]  = 3'd0;
         m_lost[p]  = 1'b0;
      end
   endtask

   task automatic model_step(input logic [7:0] r, input logic rd);
      for (int p = 0; p < 2; p++) begin
         int         sel;
         bit         free;
         logic [7:0] np;
         logic       ln;
         sel  = -1;
         free = !m_valid[p] || rd;
         if (free) begin
            for (int k = 0; k < 8; k++) begin
               int ix;
               ix = (p == 0) ? (7 - k) : k;
               if (sel < 0 && m_pend[p][ix]) sel = ix;
            end
         end
         np = m_pend[p];
         ln = 1'b0;
         if (sel >= 0) np[sel] = 1'b0;
         for (int i = 0; i < 8; i++) begin
            if (r[i] && !m_req_q[i]) begin
               if (m_pend[p][i] && i != sel) ln = 1'b1;
               np[i] = 1'b1;
            end
         end
         if (free) begin
            if (sel >= 0) begin
               m_valid[p] = 1'b1;
               m_code[p]  = 3'(sel);
            end else begin
               m_valid[p] = 1'b0;
            end
         end
         m_pend[p] = np;
         m_lost[p] = ln;
      end
      m_req_q = r;
   endtask

   task automatic check_model();
      chk("hi_valid", {7'd0, valid_hi}, {7'd0, m_valid[0]});
      chk("hi_code",  {5'd0, a_hi, b_hi, c_hi}, {5'd0, m_code[0]});
      chk("hi_pend",  pend_hi, m_pend[0]);
      chk("hi_lost",  {7'd0, lost_hi}, {7'd0, m_lost[0]});
      chk("lo_valid", {7'd0, valid_lo}, {7'd0, m_valid[1]});
      chk("lo_code",  {5'd0, a_lo, b_lo, c_lo}, {5'd0, m_code[1]});
      chk("lo_pend",  pend_lo, m_pend[1]);
      chk("lo_lost",  {7'd0, lost_lo}, {7'd0, m_lost[1]});
   endtask

   task automatic step(input logic [7:0] r, input logic rd);
      req   = r;
      ready = rd;
      @(posedge clk);
      #1;
      model_step(r, rd);
      check_model();
   endtask

   initial begin
      logic [7:0] rq;
      n_vec  = 0;
      n_fail = 0;
      rst    = 1'b1;
      req    = 8'h00;
      ready  = 1'b0;

      // req, ready | valid, code, pending, lost
      tbl[0]  = '{8'h20, 1'b0, 1'b0, 3'd0, 8'h20, 1'b0};
      tbl[1]  = '{8'h20, 1'b0, 1'b1, 3'd5, 8'h00, 1'b0};
      tbl[2]  = '{8'h20, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0};
      tbl[3]  = '{8'h00, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0};
      tbl[4]  = '{8'h81, 1'b1, 1'b0, 3'd5, 8'h81, 1'b0};
      tbl[5]  = '{8'h81, 1'b1, 1'b1, 3'd7, 8'h01, 1'b0};
      tbl[6]  = '{8'h81, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0};
      tbl[7]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
      tbl[8]  = '{8'h08, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0};
      tbl[9]  = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0};
      tbl[10] = '{8'h48, 1'b0, 1'b1, 3'd3, 8'h40, 1'b0};
      tbl[11] = '{8'h48, 1'b0, 1'b1, 3'd3, 8'h40, 1'b0};
      tbl[12] = '{8'h48, 1'b0, 1'b1, 3'd3, 8'h40, 1'b0};
      tbl[13] = '{8'h48, 1'b0, 1'b1, 3'd3, 8'h40, 1'b0};
      tbl[14] = '{8'h48, 1'b0, 1'b1, 3'd3, 8'h40, 1'b0};
      tbl[15] = '{8'h48, 1'b1, 1'b1, 3'd6, 8'h00, 1'b0};
      tbl[16] = '{8'h00, 1'b1, 1'b0, 3'd6, 8'h00, 1'b0};
      tbl[17] = '{8'h80, 1'b0, 1'b0, 3'd6, 8'h80, 1'b0};
      tbl[18] = '{8'h84, 1'b0, 1'b1, 3'd7, 8'h04, 1'b0};
      tbl[19] = '{8'h80, 1'b0, 1'b1, 3'd7, 8'h04, 1'b0};
      tbl[20] = '{8'h84, 1'b0, 1'b1, 3'd7, 8'h04, 1'b1};
      tbl[21] = '{8'h84, 1'b0, 1'b1, 3'd7, 8'h04, 1'b0};
      tbl[22] = '{8'h00, 1'b1, 1'b1, 3'd2, 8'h00, 1'b0};
      tbl[23] = '{8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0};
      tbl[24] = '{8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0};
      tbl[25] = '{8'h90, 1'b0, 1'b0, 3'd2, 8'h90, 1'b0};
      tbl[26] = '{8'h00, 1'b0, 1'b1, 3'd7, 8'h10, 1'b0};
      tbl[27] = '{8'h10, 1'b1, 1'b1, 3'd4, 8'h10, 1'b0};
      tbl[28] = '{8'h10, 1'b1, 1'b1, 3'd4, 8'h00, 1'b0};
      tbl[29] = '{8'h00, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0};

      // Reset state while rst is held.
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_valid", {7'd0, valid_hi}, 8'h00);
      chk("rst_code",  {5'd0, a_hi, b_hi, c_hi}, 8'h00);
      chk("rst_pend",  pend_hi, 8'h00);
      chk("rst_lost",  {7'd0, lost_hi}, 8'h00);
      rst = 1'b0;
      model_reset();

      for (int t = 0; t < 30; t++) begin
         step(tbl[t].req, tbl[t].ready);
         chk($sformatf("tbl%0d_valid", t), {7'd0, valid_hi}, {7'd0, tbl[t].valid});
         chk($sformatf("tbl%0d_code", t),  {5'd0, a_hi, b_hi, c_hi}, {5'd0, tbl[t].code});
         chk($sformatf("tbl%0d_pend", t),  pend_hi, tbl[t].pend);
         chk($sformatf("tbl%0d_lost", t),  {7'd0, lost_hi}, {7'd0, tbl[t].lost});
      end

      // Reset while a code is held and four events are still pending.
      step(8'h1F, 1'b0);
      step(8'h1F, 1'b0);
      chk("mid_valid_pre", {7'd0, valid_hi}, 8'h01);
      chk("mid_pend_pre",  pend_hi, 8'h0F);
      rst = 1'b1;
      #1;
      chk("mid_valid", {7'd0, valid_hi}, 8'h00);
      chk("mid_code",  {5'd0, a_hi, b_hi, c_hi}, 8'h00);
      chk("mid_pend",  pend_hi, 8'h00);
      chk("mid_valid_lo", {7'd0, valid_lo}, 8'h00);
      model_reset();
      #2;
      rst = 1'b0;
      step(8'h1F, 1'b0);
      chk("recap_pend", pend_hi, 8'h1F);
      step(8'h1F, 1'b0);
      chk("recap_valid", {7'd0, valid_hi}, 8'h01);
      chk("recap_code",  {5'd0, a_hi, b_hi, c_hi}, 8'h04);
      chk("recap_code_lo", {5'd0, a_lo, b_lo, c_lo}, 8'h00);

      // Randomized traffic with sparse line toggles and random backpressure.
      rq = 8'h1F;
      for (int n = 0; n < 800; n++) begin
         rq = rq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         step(rq, ($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
